// File: rtl/seq_key_unlock_p.sv
// Bus-snooping key-sequence unlock: qualified reads in the BA12 window must hit
// KEY_SEQ in order; once unlocked, reads return a pseudo-random LFSR stream.
`timescale 1ns/1ps
module seq_key_unlock_p #(
  parameter int ADDR_W = 4,
  parameter int KEY_LEN = 4,
  parameter logic [KEY_LEN*ADDR_W-1:0] KEY_SEQ = 16'hC9A5,
  parameter int DATA_W = 2,
  parameter int LFSR_W = 6,
  parameter logic [LFSR_W-1:0] LFSR_SEED = 6'h2D,
  parameter logic [ADDR_W-1:0] RELOCK_ADDR = 4'hF,
  parameter bit WRITE_RELOCK = 1'b1,
  parameter int MAX_FAIL = 3,
  localparam int IDX_W = $clog2(KEY_LEN),
  localparam int FAIL_W = $clog2(MAX_FAIL+1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              acc_stb,
  input  logic              sser,
  input  logic              ba13,
  input  logic              ba12,
  input  logic              br_w,
  input  logic [ADDR_W-1:0] ba_lo,
  output logic [DATA_W-1:0] sdrd,
  output logic              sdrd_oe,
  output logic              unlocked,
  output logic              locked_out,
  output logic [IDX_W-1:0]  key_idx
);
  localparam logic [1:0] SEEK = 2'd0, UNL = 2'd1, LOCK = 2'd2;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(KEY_LEN-1);
  localparam logic [FAIL_W-1:0] FAIL_LIM = FAIL_W'(MAX_FAIL-1);

  if (LFSR_SEED == '0) begin : g_bad_seed
    $error("LFSR_SEED must be non-zero");
  end
  if (DATA_W > LFSR_W) begin : g_bad_dw
    $error("DATA_W must not exceed LFSR_W");
  end

  logic [ADDR_W-1:0] key_tab [KEY_LEN];
  for (genvar g = 0; g < KEY_LEN; g++) begin : g_key
    assign key_tab[g] = KEY_SEQ[g*ADDR_W +: ADDR_W];
  end

  logic [1:0]        state;
  logic [IDX_W-1:0]  idx;
  logic [FAIL_W-1:0] fail_cnt;
  logic [LFSR_W-1:0] lfsr;
  logic              qual, qrd, hit, hit0, relock;

  assign qual   = acc_stb & ~sser & ~ba13 & ba12;
  assign qrd    = qual & br_w;
  assign hit    = (ba_lo == key_tab[idx]);
  assign hit0   = (ba_lo == key_tab[0]);
  assign relock = (ba_lo == RELOCK_ADDR);

  assign sdrd       = lfsr[DATA_W-1:0];
  assign sdrd_oe    = qrd & (state == UNL) & ~relock;
  assign unlocked   = (state == UNL);
  assign locked_out = (state == LOCK);
  assign key_idx    = idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= SEEK;
      idx      <= '0;
      fail_cnt <= '0;
      lfsr     <= LFSR_SEED;
    end else if (qual) begin
      case (state)
        SEEK: if (qrd) begin
          if (hit) begin
            if (idx == LAST_IDX) begin
              state    <= UNL;
              idx      <= '0;
              fail_cnt <= '0;
              lfsr     <= LFSR_SEED;
            end else begin
              idx <= idx + 1'b1;
            end
          end else if (idx != '0) begin
            // Counter saturates at MAX_FAIL; the limit-reaching miss locks out.
            if (fail_cnt >= FAIL_LIM) begin
              state    <= LOCK;
              idx      <= '0;
              fail_cnt <= FAIL_W'(MAX_FAIL);
            end else begin
              fail_cnt <= fail_cnt + 1'b1;
              idx      <= hit0 ? IDX_W'(1) : '0;
            end
          end
        end
        UNL: begin
          if (qrd) begin
            if (relock) begin
              state <= SEEK;
              idx   <= '0;
            end else begin
              lfsr <= {lfsr[LFSR_W-2:0], lfsr[LFSR_W-1] ^ lfsr[LFSR_W-2]};
            end
          end else if (WRITE_RELOCK) begin
            state <= SEEK;
            idx   <= '0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_key_unlock_p.sv
// Directed bench for seq_key_unlock_p: rule-level reference model checked every
// negative clock edge, plus hand-computed literal checks at key points.
`timescale 1ns/1ps
module tb_seq_key_unlock_p;
  logic       clk = 1'b0, rst_n = 1'b0;
  logic       acc_stb = 0, sser = 1, ba13 = 0, ba12 = 1, br_w = 1;
  logic [3:0] ba_lo = 0;
  logic [1:0] sdrd;
  logic       sdrd_oe, unlocked, locked_out;
  logic [1:0] key_idx;
  int checks = 0, errors = 0;

  seq_key_unlock_p dut (
    .clk(clk), .rst_n(rst_n), .acc_stb(acc_stb), .sser(sser), .ba13(ba13),
    .ba12(ba12), .br_w(br_w), .ba_lo(ba_lo), .sdrd(sdrd), .sdrd_oe(sdrd_oe),
    .unlocked(unlocked), .locked_out(locked_out), .key_idx(key_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Reference model: rule-level view of the unlock protocol.
  int key_m [4] = '{5, 10, 9, 12};
  int prog = 0, fails = 0, lf = 'h2D;
  bit m_unl = 0, m_lock = 0;

  function automatic int step(input int v);
    return ((v << 1) & 63) | (((v >> 5) ^ (v >> 4)) & 1);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prog = 0; fails = 0; lf = 'h2D; m_unl = 0; m_lock = 0;
    end else if (acc_stb && !sser && !ba13 && ba12 && !m_lock) begin
      if (m_unl) begin
        if (!br_w) begin m_unl = 0; prog = 0; end
        else if (ba_lo == 4'hF) begin m_unl = 0; prog = 0; end
        else lf = step(lf);
      end else if (br_w) begin
        if (int'(ba_lo) == key_m[prog]) begin
          prog++;
          if (prog == 4) begin m_unl = 1; prog = 0; fails = 0; lf = 'h2D; end
        end else if (prog > 0) begin
          fails++;
          if (fails >= 3) begin m_lock = 1; prog = 0; end
          else prog = (int'(ba_lo) == key_m[0]) ? 1 : 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    bit oe_m;
    oe_m = acc_stb && !sser && !ba13 && ba12 && br_w && m_unl && ba_lo != 4'hF;
    chk("m_sdrd_oe", int'(sdrd_oe), int'(oe_m));
    chk("m_sdrd", int'(sdrd), lf & 3);
    chk("m_unlocked", int'(unlocked), int'(m_unl));
    chk("m_locked_out", int'(locked_out), int'(m_lock));
    chk("m_key_idx", int'(key_idx), prog);
  end

  // Drive one access, held through the next rising edge.
  task automatic acc(input bit s, input bit q13, input bit q12, input bit rd, input logic [3:0] a, input bit stb = 1);
    @(posedge clk); #2;
    acc_stb = stb; sser = s; ba13 = q13; ba12 = q12; br_w = rd; ba_lo = a;
  endtask
  task automatic rd(input logic [3:0] a); acc(0, 0, 1, 1, a); endtask
  task automatic wr(input logic [3:0] a); acc(0, 0, 1, 0, a); endtask
  task automatic idle(); acc(1, 0, 1, 1, 4'h0, 0); endtask
  task automatic unlock_seq(); rd(5); rd(4'hA); rd(9); rd(4'hC); idle(); endtask
  task automatic pulse_rst();
    @(posedge clk); #3; rst_n = 0; #1;
    chk("rst_key_idx", int'(key_idx), 0);
    chk("rst_locked", int'(locked_out), 0);
    chk("rst_unlocked", int'(unlocked), 0);
    chk("rst_sdrd", int'(sdrd), 1);
    #2; rst_n = 1;
  endtask

  initial begin
    #12;
    chk("reset_idx", int'(key_idx), 0);
    chk("reset_oe", int'(sdrd_oe), 0);
    chk("reset_sdrd", int'(sdrd), 1);
    rst_n = 1;

    // Basic unlock, then LFSR stream, then write relock.
    rd(5); rd(4'hA); #1 chk("idx1", int'(key_idx), 1);
    rd(9); #1 chk("idx2", int'(key_idx), 2);
    rd(4'hC); #1 chk("idx3", int'(key_idx), 3);
    idle(); #1 chk("unl1", int'(unlocked), 1); chk("idx0", int'(key_idx), 0);
    rd(0); #1 chk("oe_r1", int'(sdrd_oe), 1); chk("sd_r1", int'(sdrd), 1);
    rd(0); #1 chk("sd_r2", int'(sdrd), 3);
    rd(0); #1 chk("sd_r3", int'(sdrd), 3);
    wr(0); idle(); #1 chk("wr_relock", int'(unlocked), 0);

    // Non-qualified accesses interleaved with a correct key.
    rd(5); acc(1, 0, 1, 1, 3); rd(4'hA); acc(0, 1, 1, 1, 3); wr(3);
    rd(9); acc(0, 0, 0, 1, 3); acc(0, 0, 1, 1, 3, 0); rd(4'hC); idle();
    #1 chk("nq_unl", int'(unlocked), 1);

    // Relock address, then re-unlock restarts LFSR at seed.
    rd(0); rd(4'hF); #1 chk("relock_oe", int'(sdrd_oe), 0);
    idle(); #1 chk("relock_unl", int'(unlocked), 0);
    unlock_seq(); rd(0); #1 chk("reseed_sd", int'(sdrd), 1);
    idle();

    // Fail counting, resync, lockout.
    wr(0); idle();
    rd(5); rd(4'hA); rd(3); idle(); #1 chk("fail1_idx", int'(key_idx), 0);
    rd(5); rd(5); idle(); #1 chk("resync_idx", int'(key_idx), 1);
    rd(3); idle(); #1 chk("lockout", int'(locked_out), 1);
    unlock_seq(); #1 chk("lock_abs", int'(locked_out), 1); chk("lock_unl", int'(unlocked), 0);
    pulse_rst();

    // Reset mid-sequence.
    rd(5); rd(4'hA); rd(9); idle(); #1 chk("pre_rst_idx", int'(key_idx), 3);
    pulse_rst();
    unlock_seq(); #1 chk("post_rst_unl", int'(unlocked), 1);
    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
